// File: rtl/cordic_polar_arb.sv
// Round-robin arbiter that shares one iterative rectangular-to-polar CORDIC core
// between NREQ requesters. Only one vector is in the core at a time, because the
// core cannot be stalled. Each result is tagged with the index of its requester
// and held in an output register until downstream accepts it. A watchdog and a
// sticky error flag catch a core that hangs or produces unexpected strobes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_vld/req_rdy   per-requester handshake (req_rdy is one-hot or zero)
//   req_x/req_y       packed vectors, requester i at [i*WIDTH_XY +: WIDTH_XY]
//   core_i_*          vector issued to the core (core_i_vld is a single-cycle strobe)
//   core_ready        core is idle and can accept a vector
//   core_o_*          core result strobe and data
//   out_*             registered result, valid/ready handshake, requester tag
//   busy              state is not idle
//   err               sticky: watchdog timeout or unexpected core strobe
module cordic_polar_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH_XY = 32,
  parameter int unsigned WIDTH_PH = 32,
  parameter int unsigned NSTAGES  = 16,
  parameter int unsigned TMO      = NSTAGES + 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_vld,
  output logic [NREQ-1:0]              req_rdy,
  input  logic [NREQ*WIDTH_XY-1:0]     req_x,
  input  logic [NREQ*WIDTH_XY-1:0]     req_y,
  output logic                         core_i_vld,
  output logic [WIDTH_XY-1:0]          core_i_x,
  output logic [WIDTH_XY-1:0]          core_i_y,
  input  logic                         core_ready,
  input  logic                         core_o_vld,
  input  logic [WIDTH_XY-1:0]          core_o_mag,
  input  logic [WIDTH_PH-1:0]          core_o_phase,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [WIDTH_XY-1:0]          out_mag,
  output logic [WIDTH_PH-1:0]          out_phase,
  output logic [$clog2(NREQ)-1:0]      out_id,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      last_q, last_d;
  logic [IdW-1:0]      tag_q, tag_d;
  logic [CntW-1:0]     wdog_q, wdog_d;
  logic [CntW-1:0]     wdog_inc;
  logic [WIDTH_XY-1:0] mag_q, mag_d;
  logic [WIDTH_PH-1:0] phase_q, phase_d;
  logic [IdW-1:0]      id_q, id_d;
  logic                err_q, err_d;

  logic                gnt_found;
  logic [IdW-1:0]      gnt_idx;
  logic                hi_found, lo_found;
  logic [IdW-1:0]      hi_idx, lo_idx;
  logic                grant;
  logic [IdW-1:0]      sel;

  // Round-robin search: the lowest valid index above the last grant wins; if none,
  // wrap around to the lowest valid index overall. Scanning downward lets the last
  // assignment in each category be the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        lo_found = 1'b1;
        lo_idx   = IdW'(i);
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = IdW'(i);
        end
      end
    end
    gnt_found = lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign grant = (state_q == StIdle) && gnt_found && core_ready;

  // Outside a grant the core sees requester 0, so its inputs never float.
  assign sel        = grant ? gnt_idx : '0;
  assign core_i_vld = grant;
  assign core_i_x   = req_x[int'(sel)*WIDTH_XY +: WIDTH_XY];
  assign core_i_y   = req_y[int'(sel)*WIDTH_XY +: WIDTH_XY];

  always_comb begin
    req_rdy = '0;
    if (grant) begin
      req_rdy[gnt_idx] = 1'b1;
    end
  end

  assign wdog_inc = wdog_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tag_d   = tag_q;
    wdog_d  = wdog_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        // A strobe with nothing in flight means the core is misbehaving.
        if (core_o_vld) begin
          err_d = 1'b1;
        end
        if (grant) begin
          last_d  = gnt_idx;
          tag_d   = gnt_idx;
          wdog_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (core_o_vld) begin
          mag_d   = core_o_mag;
          phase_d = core_o_phase;
          id_d    = tag_q;
          wdog_d  = '0;
          state_d = StHold;
        end else if (wdog_inc == CntW'(TMO)) begin
          // Core hung: drop the vector and free the arbiter.
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      StHold: begin
        if (core_o_vld) begin
          err_d = 1'b1;
        end
        if (out_rdy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= IdW'(NREQ - 1);
      tag_q   <= '0;
      wdog_q  <= '0;
      mag_q   <= '0;
      phase_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      wdog_q  <= wdog_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign out_vld   = (state_q == StHold);
  assign out_mag   = mag_q;
  assign out_phase = phase_q;
  assign out_id    = id_q;
  assign busy      = (state_q != StIdle);
  assign err       = err_q;

endmodule

// File: tb/tb_cordic_polar_arb.sv
// Bench for cordic_polar_arb: a behavioural CORDIC stub, a negedge monitor that
// checks every cycle against a spec-level model and a result scoreboard, and a
// stimulus process covering directed scenarios and a randomized phase.
module tb_cordic_polar_arb;

  localparam int NREQ    = 4;
  localparam int WXY     = 32;
  localparam int WPH     = 32;
  localparam int NSTAGES = 16;
  localparam int TMO     = NSTAGES + 4;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*WXY-1:0]   req_x;
  logic [NREQ*WXY-1:0]   req_y;
  logic                  core_i_vld;
  logic [WXY-1:0]        core_i_x;
  logic [WXY-1:0]        core_i_y;
  logic                  core_ready;
  logic                  core_o_vld;
  logic [WXY-1:0]        core_o_mag;
  logic [WPH-1:0]        core_o_phase;
  logic                  out_vld;
  logic                  out_rdy;
  logic [WXY-1:0]        out_mag;
  logic [WPH-1:0]        out_phase;
  logic [IDW-1:0]        out_id;
  logic                  busy;
  logic                  err;

  always #5 clk = ~clk;

  cordic_polar_arb #(
    .NREQ    (NREQ),
    .WIDTH_XY(WXY),
    .WIDTH_PH(WPH),
    .NSTAGES (NSTAGES),
    .TMO     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_x       (req_x),
    .req_y       (req_y),
    .core_i_vld  (core_i_vld),
    .core_i_x    (core_i_x),
    .core_i_y    (core_i_y),
    .core_ready  (core_ready),
    .core_o_vld  (core_o_vld),
    .core_o_mag  (core_o_mag),
    .core_o_phase(core_o_phase),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_mag     (out_mag),
    .out_phase   (out_phase),
    .out_id      (out_id),
    .busy        (busy),
    .err         (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo,
                           input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Behavioural core: magnitude with CORDIC gain, phase in degrees Q9.22.
  function automatic logic [WXY-1:0] core_mag(input logic [WXY-1:0] x, input logic [WXY-1:0] y);
    real rx = $itor($signed(x));
    real ry = $itor($signed(y));
    return WXY'($rtoi($sqrt(rx * rx + ry * ry) * 2.3289 + 0.5));
  endfunction

  function automatic logic [WPH-1:0] core_phase(input logic [WXY-1:0] x,
                                               input logic [WXY-1:0] y);
    real rx = $itor($signed(x));
    real ry = $itor($signed(y));
    real p  = $atan2(ry, rx) * 180.0 / 3.14159265358979 * 4194304.0;
    return WPH'($rtoi((p >= 0.0) ? p + 0.5 : p - 0.5));
  endfunction

  function automatic logic [WXY-1:0] slice(input logic [NREQ*WXY-1:0] v, input int i);
    return v[i*WXY +: WXY];
  endfunction

  // ---------------- core stub ----------------
  int             core_cnt;
  logic [WXY-1:0] c_x, c_y;
  logic           hang, spur, core_block;

  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= 0;
      c_x      <= '0;
      c_y      <= '0;
    end else if (core_i_vld) begin
      core_cnt <= NSTAGES + 1;
      c_x      <= core_i_x;
      c_y      <= core_i_y;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign core_ready   = (core_cnt == 0) && !core_block;
  assign core_o_vld   = ((core_cnt == 1) && !hang) || spur;
  assign core_o_mag   = core_mag(c_x, c_y);
  assign core_o_phase = core_phase(c_x, c_y);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model + scoreboard monitor ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [WXY-1:0] mag;
    logic [WPH-1:0] ph;
  } exp_t;

  exp_t           sb[$];
  int             grant_log[$];
  int             ptr;
  int             outstanding;
  int             gcyc;
  bit             ghang;
  bit             m_err;
  bit             prev_ov;
  int             rise_lat = -1;
  int             n_results = 0;
  logic [IDW-1:0] last_id;
  logic [WXY-1:0] last_mag;
  logic [WPH-1:0] last_ph;
  logic [WPH-1:0] ph_by_id[NREQ];
  bit             seen_id[NREQ];

  always @(negedge clk) begin
    int   exp_g;
    bit   want;
    bit   ov;
    exp_t e;
    if (rst) begin
      ptr         = NREQ - 1;
      outstanding = 0;
      m_err       = 1'b0;
      prev_ov     = 1'b0;
      sb.delete();
    end else begin
      chk("err", err, m_err);
      chk("busy", busy, outstanding > 0);

      want  = (outstanding == 0) && (req_vld != 0) && core_ready;
      exp_g = -1;
      if (want) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (exp_g < 0 && req_vld[(ptr + k) % NREQ]) exp_g = (ptr + k) % NREQ;
        end
      end
      chk("core_i_vld", core_i_vld, want);
      chk("req_rdy", req_rdy, want ? (1 << exp_g) : 0);
      chk("core_i_x", core_i_x, slice(req_x, want ? exp_g : 0));
      chk("core_i_y", core_i_y, slice(req_y, want ? exp_g : 0));

      ov = (outstanding > 0) && !ghang && (cyc >= gcyc + NSTAGES + 2);
      chk("out_vld", out_vld, ov);
      if (out_vld && !prev_ov) rise_lat = cyc - gcyc;
      prev_ov = out_vld;

      if (ov && sb.size() > 0) begin
        chk("out_id", out_id, sb[0].id);
        chk("out_mag", out_mag, sb[0].mag);
        chk("out_phase", out_phase, sb[0].ph);
        if (out_rdy) begin
          e = sb.pop_front();
          last_id  = out_id;
          last_mag = out_mag;
          last_ph  = out_phase;
          ph_by_id[out_id] = out_phase;
          seen_id[out_id]  = 1'b1;
          n_results++;
          outstanding = 0;
        end
      end

      // Watchdog: the vector is dropped after TMO wait cycles.
      if (outstanding > 0 && ghang && cyc == gcyc + TMO) begin
        outstanding = 0;
        if (sb.size() > 0) e = sb.pop_front();
        m_err = 1'b1;
      end

      if (core_o_vld && !(outstanding > 0 && !ghang && cyc == gcyc + NSTAGES + 1)) begin
        m_err = 1'b1;
      end

      if (want) begin
        ptr         = exp_g;
        outstanding = 1;
        gcyc        = cyc;
        ghang       = hang;
        grant_log.push_back(exp_g);
        e.id  = IDW'(exp_g);
        e.mag = core_mag(slice(req_x, exp_g), slice(req_y, exp_g));
        e.ph  = core_phase(slice(req_x, exp_g), slice(req_y, exp_g));
        sb.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y);
    req_x[i*WXY +: WXY] = x;
    req_y[i*WXY +: WXY] = y;
  endtask

  function automatic int rnd_coord();
    return int'($urandom_range(0, 2097151)) - 1048576;
  endfunction

  task automatic wait_results(input int n, input int budget, input string name);
    int start = n_results;
    int c = 0;
    while (n_results < start + n && c < budget) begin
      tick();
      c++;
    end
    chk(name, n_results - start, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    int c;
    int ph;
    rst        = 1'b1;
    req_vld    = '0;
    req_x      = '0;
    req_y      = '0;
    out_rdy    = 1'b1;
    hang       = 1'b0;
    spur       = 1'b0;
    core_block = 1'b0;
    repeat (3) tick();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_phase", out_phase, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single request from requester 0.
    set_req(0, 1000, 0);
    req_vld = 4'b0001;
    tick();
    req_vld = '0;
    wait_results(1, 100, "single_done");
    chk("single_latency", rise_lat, NSTAGES + 2);
    chk_range("single_mag", last_mag, 2325, 2333);
    ph = $signed(last_ph);
    chk_range("single_phase", ph, -65536, 65536);
    chk("single_id", last_id, 0);

    // Round-robin from reset with all requesters continuously valid.
    do_reset();
    grant_log.delete();
    set_req(0, 1000, 0);
    set_req(1, 700, 700);
    set_req(2, 0, 1000);
    set_req(3, -1000, 0);
    req_vld = 4'hF;
    wait_results(5, 200, "rr_done");
    req_vld = '0;
    chk("rr_ngrants", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % NREQ);
    chk("rr_seen2", seen_id[2], 1);
    ph = $signed(ph_by_id[2]);
    chk_range("rr_phase2", ph, 32'h1680_0000 - 65536, 32'h1680_0000 + 65536);

    // Backpressure: result held for 50 cycles with other requests pending.
    out_rdy = 1'b0;
    req_vld = 4'hF;
    c = 0;
    while (!out_vld && c < 100) begin
      tick();
      c++;
    end
    chk("bp_out_vld", out_vld, 1);
    n0 = n_results;
    repeat (50) tick();
    chk("bp_held_vld", out_vld, 1);
    chk("bp_busy", busy, 1);
    chk("bp_no_xfer", n_results, n0);
    req_vld = '0;
    out_rdy = 1'b1;
    repeat (2) tick();
    chk("bp_one_xfer", n_results, n0 + 1);
    chk("bp_idle", busy, 0);

    // Randomized traffic.
    n0 = n_results;
    for (int k = 0; k < 3000 && n_results < n0 + 30; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_vld[i] = ($urandom_range(0, 2) != 0);
        set_req(i, rnd_coord(), rnd_coord());
      end
      out_rdy    = ($urandom_range(0, 3) != 0);
      core_block = ($urandom_range(0, 9) == 0);
      tick();
    end
    chk("rand_results", n_results >= n0 + 30, 1);
    req_vld    = '0;
    out_rdy    = 1'b1;
    core_block = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    chk("rand_drain", busy, 0);

    // Watchdog: the core never answers.
    hang = 1'b1;
    n0 = n_results;
    set_req(1, 5, 6);
    req_vld = 4'b0010;
    tick();
    req_vld = '0;
    c = 0;
    while (!err && c < 60) begin
      tick();
      c++;
    end
    chk("wd_err", err, 1);
    chk("wd_timing", cyc - gcyc, TMO + 1);
    chk("wd_idle", busy, 0);
    chk("wd_dropped", n_results, n0);
    hang = 1'b0;
    set_req(3, -300, 400);
    req_vld = 4'b1000;
    tick();
    req_vld = '0;
    wait_results(1, 100, "wd_next_done");
    chk("wd_next_id", last_id, 3);

    // Reset in the eighth wait cycle.
    set_req(0, 123, 456);
    req_vld = 4'b0001;
    tick();
    req_vld = '0;
    repeat (7) tick();
    chk("mid_busy_before", busy, 1);
    rst     = 1'b1;
    req_vld = 4'hF;
    tick();
    rst = 1'b0;
    chk("mid_idle", busy, 0);
    chk("mid_out_vld", out_vld, 0);
    chk("mid_err", err, 0);
    tick();
    req_vld = '0;
    chk("mid_next_grant", grant_log[grant_log.size() - 1], 0);
    wait_results(1, 100, "mid_next_done");

    // Spurious strobe while idle.
    repeat (2) tick();
    chk("spur_err_before", err, 0);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("spur_err", err, 1);
    chk("spur_out_vld", out_vld, 0);
    chk("spur_idle", busy, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cordic_polar_arb.md
Name: cordic_polar_arb

Overview:
- Round-robin arbiter and sequencer that shares one iterative rectangular-to-polar CORDIC core between NREQ requesters, for example several FFT channels' bin streams in the postprocess path.
- The CORDIC core has no output backpressure, so this block issues one vector at a time and tags the result with the requester index.
- It holds the result in an output register until downstream accepts it.
- A watchdog and a sticky error flag detect a core that hangs or misbehaves.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH_XY, 32, signed x/y/magnitude width.
- WIDTH_PH, 32, signed phase width (degrees: 1 sign bit, 9 integer bits, 22 fractional bits).
- NSTAGES, 16, CORDIC iteration count of the attached core.
- TMO, NSTAGES+4, watchdog limit in WAIT cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- req_vld  in  NREQ  per-requester valid
- req_rdy  out  NREQ  per-requester ready (one-hot or zero)
- req_x  in  NREQ*WIDTH_XY  packed x; requester i occupies bits [i*WIDTH_XY +: WIDTH_XY]
- req_y  in  NREQ*WIDTH_XY  packed y, same packing
- core_i_vld  out  1  core input valid
- core_i_x  out  WIDTH_XY  core x
- core_i_y  out  WIDTH_XY  core y
- core_ready  in  1  core ready (high when core not iterating)
- core_o_vld  in  1  core result strobe (single cycle)
- core_o_mag  in  WIDTH_XY  core magnitude
- core_o_phase  in  WIDTH_PH  core phase
- out_vld  out  1  result valid
- out_rdy  in  1  downstream ready
- out_mag  out  WIDTH_XY  registered magnitude
- out_phase  out  WIDTH_PH  registered phase
- out_id  out  $clog2(NREQ)  requester index of the result
- busy  out  1  high whenever the state is not IDLE
- err  out  1  sticky error flag

Behaviour:
- States: IDLE, WAIT, HOLD.
- Reset values:
  - State goes to IDLE.
  - out_vld=0, out_mag=0, out_phase=0, out_id=0, err=0.
  - Round-robin pointer is set to last grant = NREQ-1, so index 0 has first priority.
  - Watchdog counter = 0.
- IDLE:
  - Combinationally, g = first i with req_vld[i]=1, searching from (last+1) mod NREQ upward with wrap.
  - When any req_vld is set and core_ready=1: req_rdy[g]=1, core_i_vld=1, core_i_x/y = the slice for requester g.
  - On that clock edge: latch g as the tag and as the new last grant, then go to WAIT.
  - If core_ready=0, all req_rdy and core_i_vld stay low.
- core_i_x/y outside a grant cycle: drive requester 0's slice. The value is don't-care but must be deterministic.
- core_i_vld is only ever high in IDLE, and never for more than one cycle per grant.
- WAIT:
  - The watchdog counts up each cycle.
  - When core_o_vld=1: register core_o_mag and core_o_phase into out_mag/out_phase, out_id = tag, go to HOLD, clear the watchdog.
  - If the counter reaches TMO with no strobe: set err, clear the counter, return to IDLE. out_vld stays 0 and the vector is dropped.
- Latency: a grant in cycle t gives core_o_vld in t+NSTAGES+1 and out_vld=1 from t+NSTAGES+2.
- HOLD:
  - out_vld=1, and out_mag/out_phase/out_id are stable until the handshake.
  - On out_vld & out_rdy: go to IDLE and deassert out_vld the next cycle.
  - A new grant is not possible before the next cycle.
  - Maximum throughput: one result per NSTAGES+3 cycles when out_rdy is tied high.
- core_o_vld arriving in IDLE or HOLD: ignore the data and set err.
- Arbitration: a requester that drops req_vld before being granted loses its turn with no side effects. Pointer advance depends only on grants.
- Fairness: with all requesters continuously valid, grants go 0,1,…,NREQ-1,0,…
- err: cleared only by rst.
- Reset mid-operation: rst in any state forces the reset values on the next edge. The arbiter does not wait for the core; the core is reset by the same rst.
- No arithmetic on the data; values pass through unchanged and signed.

Test Plan:
- Single request: req0 (x=1000, y=0), out_rdy=1 → req_rdy[0] high for one cycle; out_vld rises exactly 18 cycles after the grant (NSTAGES=16). Expected out_mag ≈2329 (±4; core gain ≈√2·1.6468), out_phase ≈0x0000_0000 (±0x0001_0000), out_id=0.
- Round-robin: all 4 requests held valid with distinct vectors, including req2 (0, 1000) → grant order 0,1,2,3,0. out_id for req2's result is 2, with out_phase ≈0x1680_0000 (90°).
- Backpressure: out_rdy=0 for 50 cycles after out_vld → out_* stable; no req_rdy asserted; busy=1. Raising out_rdy → exactly one transfer, then IDLE.
- Watchdog: stub core that never pulses core_o_vld → err=1 after TMO=20 WAIT cycles; returns to IDLE and accepts the next request.
- Spurious strobe: core_o_vld pulsed in IDLE → err=1; out_vld stays 0.
- Reset during WAIT at cycle 8 → next cycle: state IDLE, out_vld=0, err=0; the following grant goes to index 0.
